// File: rtl/instruction_fetch_mem_if.sv
// Bus bundle for instruction_fetch_mem: load port, fetch control and fetched-pair outputs.
// The fault signal exists only when IMEM_FAULT_EN is defined.
interface instruction_fetch_mem_if #(
    parameter int Num_of_bits      = 16,
    parameter int pc_width         = 32,
    parameter int Num_of_registers = 5
);
    logic                        load_en;
    logic [Num_of_registers-1:0] load_addr;
    logic [Num_of_bits-1:0]      load_data;
    logic                        fetch_req;
    logic                        stall;
    logic                        flush;
    logic [pc_width-1:0]         pc;
    logic [Num_of_bits-1:0]      instruction;
    logic [Num_of_bits-1:0]      immediate;
    logic                        fetch_valid;
    logic [15:0]                 fetch_count;
`ifdef IMEM_FAULT_EN
    logic                        fault;
`endif

    modport master (
        output load_en, load_addr, load_data, fetch_req, stall, flush, pc,
        input  instruction, immediate, fetch_valid, fetch_count
`ifdef IMEM_FAULT_EN
        , input fault
`endif
    );

    modport slave (
        input  load_en, load_addr, load_data, fetch_req, stall, flush, pc,
        output instruction, immediate, fetch_valid, fetch_count
`ifdef IMEM_FAULT_EN
        , output fault
`endif
    );
endinterface

// File: rtl/instruction_fetch_mem.sv
// Loadable instruction memory returning a registered {mem[pc], mem[pc+1]} pair per accepted fetch.
// Define IMEM_FAULT_EN to add out-of-range detection and the fault output.
module instruction_fetch_mem #(
    parameter int                     Num_of_bits      = 16,
    parameter int                     pc_width         = 32,
    parameter int                     Num_of_registers = 5,
    parameter logic [Num_of_bits-1:0] NOP_WORD         = {Num_of_bits{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    instruction_fetch_mem_if.slave  bus
);
    localparam int AW    = Num_of_registers;
    localparam int DEPTH = 2 ** Num_of_registers;
`ifdef IMEM_FAULT_EN
    localparam logic [pc_width-1:0] LAST_IDX = pc_width'(DEPTH - 1);
`endif

    logic [Num_of_bits-1:0] mem_q [DEPTH];
    logic [Num_of_bits-1:0] mem_d [DEPTH];
    logic [Num_of_bits-1:0] instruction_q, instruction_d;
    logic [Num_of_bits-1:0] immediate_q, immediate_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [15:0]            fetch_count_q, fetch_count_d;
    logic [AW-1:0]          rd0_s, rd1_s;
    logic [Num_of_bits-1:0] rd0_data_s, rd1_data_s;
`ifdef IMEM_FAULT_EN
    logic                   fault_q, fault_d;
    logic                   out_of_range_s;
`endif

    // Read addresses wrap inside the memory; a same-cycle load to either address is forwarded.
    always_comb begin
        rd0_s = bus.pc[AW-1:0];
        rd1_s = rd0_s + AW'(1'b1);
        if (bus.load_en && (bus.load_addr == rd0_s)) begin
            rd0_data_s = bus.load_data;
        end else begin
            rd0_data_s = mem_q[rd0_s];
        end
        if (bus.load_en && (bus.load_addr == rd1_s)) begin
            rd1_data_s = bus.load_data;
        end else begin
            rd1_data_s = mem_q[rd1_s];
        end
    end

    // Memory write port; loads proceed independently of stall and flush.
    always_comb begin
        mem_d = mem_q;
        if (bus.load_en) begin
            mem_d[bus.load_addr] = bus.load_data;
        end else begin
            mem_d = mem_q;
        end
    end

`ifdef IMEM_FAULT_EN
    // pc >= DEPTH-1 means pc or pc+1 lies outside the array.
    always_comb begin
        out_of_range_s = (bus.pc >= LAST_IDX);
    end
`endif

    // Output next-state: flush beats stall, stall beats a fetch request.
    always_comb begin
        instruction_d = instruction_q;
        immediate_d   = immediate_q;
        fetch_valid_d = fetch_valid_q;
        fetch_count_d = fetch_count_q;
`ifdef IMEM_FAULT_EN
        fault_d       = fault_q;
`endif
        if (bus.flush) begin
            instruction_d = NOP_WORD;
            immediate_d   = NOP_WORD;
            fetch_valid_d = 1'b0;
`ifdef IMEM_FAULT_EN
            fault_d       = 1'b0;
`endif
        end else if (bus.stall) begin
            fetch_valid_d = fetch_valid_q;
        end else if (bus.fetch_req) begin
            fetch_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 16'd1;
`ifdef IMEM_FAULT_EN
            fault_d = out_of_range_s;
            if (out_of_range_s) begin
                instruction_d = NOP_WORD;
                immediate_d   = NOP_WORD;
            end else begin
                instruction_d = rd0_data_s;
                immediate_d   = rd1_data_s;
            end
`else
            instruction_d = rd0_data_s;
            immediate_d   = rd1_data_s;
`endif
        end else begin
            fetch_valid_d = 1'b0;
        end
    end

    // State registers; reset also clears every memory word and blocks that cycle's load.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q         <= '{default: NOP_WORD};
            instruction_q <= NOP_WORD;
            immediate_q   <= NOP_WORD;
            fetch_valid_q <= 1'b0;
            fetch_count_q <= 16'd0;
`ifdef IMEM_FAULT_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            mem_q         <= mem_d;
            instruction_q <= instruction_d;
            immediate_q   <= immediate_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_count_q <= fetch_count_d;
`ifdef IMEM_FAULT_EN
            fault_q       <= fault_d;
`endif
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.immediate   = immediate_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_count = fetch_count_q;
`ifdef IMEM_FAULT_EN
    assign bus.fault       = fault_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Directed self-checking bench for instruction_fetch_mem (default parameters).
// Honours IMEM_FAULT_EN for the out-of-range scenario.
module tb_instruction_fetch_mem;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    instruction_fetch_mem_if bus_if ();

    instruction_fetch_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.load_en   = 1'b0;
        bus_if.load_addr = 5'd0;
        bus_if.load_data = 16'h0000;
        bus_if.fetch_req = 1'b0;
        bus_if.stall     = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.pc        = 32'd0;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [15:0] d);
        bus_if.load_en   = 1'b1;
        bus_if.load_addr = a;
        bus_if.load_data = d;
        tick();
        bus_if.load_en   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] p);
        bus_if.fetch_req = 1'b1;
        bus_if.pc        = p;
        tick();
        bus_if.fetch_req = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [15:0] ins, input logic [15:0] imm,
                             input logic vld, input logic [15:0] cnt);
        vectors++;
        if (bus_if.instruction !== ins) begin
            miscompares++;
            $display("FAIL %s instruction: got %h expected %h", name, bus_if.instruction, ins);
        end
        vectors++;
        if (bus_if.immediate !== imm) begin
            miscompares++;
            $display("FAIL %s immediate: got %h expected %h", name, bus_if.immediate, imm);
        end
        vectors++;
        if (bus_if.fetch_valid !== vld) begin
            miscompares++;
            $display("FAIL %s fetch_valid: got %b expected %b", name, bus_if.fetch_valid, vld);
        end
        vectors++;
        if (bus_if.fetch_count !== cnt) begin
            miscompares++;
            $display("FAIL %s fetch_count: got %h expected %h", name, bus_if.fetch_count, cnt);
        end
    endtask

`ifdef IMEM_FAULT_EN
    task automatic check_fault(input string name, input logic f);
        vectors++;
        if (bus_if.fault !== f) begin
            miscompares++;
            $display("FAIL %s fault: got %b expected %b", name, bus_if.fault, f);
        end
    endtask
`endif

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
`ifdef IMEM_FAULT_EN
        check_fault("reset", 1'b0);
`endif
    endtask

    task automatic test_fetch();
        load_word(5'd3, 16'h1234);
        load_word(5'd4, 16'h00AB);
        fetch(32'd3);
        check_out("fetch_pc3", 16'h1234, 16'h00AB, 1'b1, 16'd1);
    endtask

    task automatic test_stall();
        bus_if.stall     = 1'b1;
        bus_if.fetch_req = 1'b1;
        bus_if.pc        = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall_hold", 16'h1234, 16'h00AB, 1'b1, 16'd1);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        bus_if.flush     = 1'b1;
        bus_if.stall     = 1'b1;
        bus_if.fetch_req = 1'b1;
        bus_if.pc        = 32'd3;
        tick();
        idle_inputs();
        check_out("flush", 16'h0000, 16'h0000, 1'b0, 16'd1);
    endtask

    task automatic test_idle();
        fetch(32'd3);
        check_out("refetch", 16'h1234, 16'h00AB, 1'b1, 16'd2);
        tick();
        check_out("idle", 16'h1234, 16'h00AB, 1'b0, 16'd2);
    endtask

    task automatic test_forward();
        bus_if.load_en   = 1'b1;
        bus_if.load_addr = 5'd7;
        bus_if.load_data = 16'hBEEF;
        fetch(32'd6);
        bus_if.load_en   = 1'b0;
        check_out("fwd_immediate", 16'h0000, 16'hBEEF, 1'b1, 16'd3);
        bus_if.load_en   = 1'b1;
        bus_if.load_addr = 5'd9;
        bus_if.load_data = 16'h5A5A;
        fetch(32'd9);
        bus_if.load_en   = 1'b0;
        check_out("fwd_instruction", 16'h5A5A, 16'h0000, 1'b1, 16'd4);
        fetch(32'd7);
        check_out("fwd_stored", 16'hBEEF, 16'h0000, 1'b1, 16'd5);
    endtask

    task automatic test_wrap();
        load_word(5'd31, 16'h1111);
        load_word(5'd0, 16'h2222);
        fetch(32'd31);
`ifdef IMEM_FAULT_EN
        check_out("fault_pc31", 16'h0000, 16'h0000, 1'b1, 16'd6);
        check_fault("fault_pc31", 1'b1);
        fetch(32'd35);
        check_out("fault_pc35", 16'h0000, 16'h0000, 1'b1, 16'd7);
        check_fault("fault_pc35", 1'b1);
        fetch(32'd3);
        check_fault("fault_clear", 1'b0);
`else
        check_out("wrap_pc31", 16'h1111, 16'h2222, 1'b1, 16'd6);
        fetch(32'd35);
        check_out("trunc_pc35", 16'h1234, 16'h00AB, 1'b1, 16'd7);
        fetch(32'd3);
`endif
        check_out("after_wrap", 16'h1234, 16'h00AB, 1'b1, 16'd8);
    endtask

    task automatic test_reset_in_stall();
        bus_if.stall     = 1'b1;
        bus_if.fetch_req = 1'b1;
        bus_if.pc        = 32'd3;
        bus_if.load_en   = 1'b1;
        bus_if.load_addr = 5'd3;
        bus_if.load_data = 16'hFFFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        check_out("rst_in_stall", 16'h0000, 16'h0000, 1'b0, 16'd0);
        fetch(32'd3);
        check_out("first_after_rst", 16'h0000, 16'h0000, 1'b1, 16'd1);
    endtask

    task automatic test_count_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.fetch_req = 1'b1;
        bus_if.pc        = 32'd3;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check_out("count_ffff", 16'h0000, 16'h0000, 1'b1, 16'hFFFF);
        tick();
        bus_if.fetch_req = 1'b0;
        check_out("count_wrap", 16'h0000, 16'h0000, 1'b1, 16'h0000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_idle();
        test_forward();
        test_wrap();
        test_reset_in_stall();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_mem.md
INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

Interface
REQ-001 Parameter Num_of_bits, default 16: instruction/immediate word width.
REQ-002 Parameter pc_width, default 32: program-counter width.
REQ-003 Parameter Num_of_registers, default 5: address bits; depth DEPTH = 2**Num_of_registers words.
REQ-004 Parameter NOP_WORD, default 0 (Num_of_bits wide): word returned on flush, reset and fault.
REQ-005 One clock, reset synchronous and active-high: clk, rst.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 load_en  in  1  write one word into memory this cycle.
REQ-009 load_addr  in  Num_of_registers  write address.
REQ-010 load_data  in  Num_of_bits  write data.
REQ-011 fetch_req  in  1  request fetch at pc.
REQ-012 stall  in  1  hold outputs unchanged.
REQ-013 flush  in  1  discard output, force NOP.
REQ-014 pc  in  pc_width  fetch address (word address).
REQ-015 instruction  out  Num_of_bits  registered mem[pc].
REQ-016 immediate  out  Num_of_bits  registered mem[pc+1].
REQ-017 fetch_valid  out  1  instruction/immediate hold a fetched pair.
REQ-018 fetch_count  out  16  number of accepted fetches, wraps 0xFFFF->0.
REQ-019 fault  out  1  present only with IMEM_FAULT_EN; out-of-range fetch.

Function
REQ-020 Memory: DEPTH x Num_of_bits register array; written at rising edge when load_en=1.
REQ-021 Accepted fetch = fetch_req & !stall & !flush; outputs updated exactly one cycle later (latency 1).
REQ-022 Accepted fetch: instruction <= mem[pc], immediate <= mem[pc+1], fetch_valid <= 1, fetch_count <= fetch_count+1.
REQ-023 Priority per cycle: rst > flush > stall > fetch_req > idle.
REQ-024 flush: instruction <= NOP_WORD, immediate <= NOP_WORD, fetch_valid <= 0; fetch_count unchanged.
REQ-025 stall (no flush): instruction, immediate, fetch_valid, fetch_count hold values.
REQ-026 Idle (no req, no stall, no flush): fetch_valid <= 0; instruction/immediate hold.
REQ-027 Write-first forwarding: load_en with load_addr equal to either read address in an accepted-fetch cycle returns load_data on that output.
REQ-028 load_en is honoured regardless of stall/flush; only rst blocks it.
REQ-029 Address arithmetic: pc+1 computed in Num_of_registers bits; index DEPTH-1 +1 wraps to 0.

Reset
REQ-030 On rst: instruction=NOP_WORD, immediate=NOP_WORD, fetch_valid=0, fetch_count=0, fault=0, all memory words=NOP_WORD.
REQ-031 rst asserted mid-stall or with fetch_req/load_en: reset wins; no write, no fetch that cycle.
REQ-032 First fetch may be accepted in the cycle after rst deasserts.

Configuration
REQ-033 Macro IMEM_FAULT_EN compiles in range checking and the fault port.
REQ-034 With IMEM_FAULT_EN: accepted fetch with pc >= DEPTH-1 (pc or pc+1 out of range) sets fault <= 1, instruction/immediate <= NOP_WORD, fetch_valid <= 1, counts; any other accepted fetch or flush clears fault; stall holds it.
REQ-035 Without IMEM_FAULT_EN: no fault port; pc truncated to low Num_of_registers bits, wraps per REQ-029.

Verification
REQ-036 rst 1 cycle, load mem[3]=0x1234, mem[4]=0x00AB; fetch pc=3 -> next cycle instruction=0x1234, immediate=0x00AB, fetch_valid=1, fetch_count=1.
REQ-037 After REQ-036, stall=1 with fetch_req, pc=0 for 3 cycles -> outputs stay 0x1234/0x00AB, fetch_valid=1, fetch_count=1.
REQ-038 flush=1 and stall=1 and fetch_req=1 same cycle -> next cycle instruction=immediate=0x0000, fetch_valid=0, count unchanged.
REQ-039 load_en addr 7 data 0xBEEF and fetch pc=6 same cycle -> immediate=0xBEEF next cycle.
REQ-040 Without IMEM_FAULT_EN, mem[31]=0x1111, mem[0]=0x2222, fetch pc=31 -> instruction=0x1111, immediate=0x2222; with IMEM_FAULT_EN -> fault=1, both outputs 0x0000, fetch_valid=1.
REQ-041 65536 accepted fetches from reset -> fetch_count=0x0000; rst during stall -> all outputs at reset values next cycle.
